// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: bundles the interrupt sequencer's request/redirect signals.
//   master : used by intr_ctrl. It receives IRQ, INSTR_DONE, MRET and the CSR
//            values, and drives INT_TAKEN, PC_REDIRECT, TRAP_PC, MIE_RESTORE,
//            CAUSE, IN_ISR and PENDING.
//   slave  : used by the CPU FSM and CSR file side, with the opposite directions.
interface intr_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0] IRQ;
    logic               INSTR_DONE;
    logic               MRET;
    logic               CSR_MIE;
    logic [31:0]        CSR_MTVEC;
    logic [31:0]        CSR_MEPC;
    logic               INT_TAKEN;
    logic               PC_REDIRECT;
    logic [31:0]        TRAP_PC;
    logic               MIE_RESTORE;
    logic [CAUSE_W-1:0] CAUSE;
    logic               IN_ISR;
    logic [NUM_SRC-1:0] PENDING;

    modport master (
        input  IRQ, INSTR_DONE, MRET, CSR_MIE, CSR_MTVEC, CSR_MEPC,
        output INT_TAKEN, PC_REDIRECT, TRAP_PC, MIE_RESTORE, CAUSE, IN_ISR, PENDING
    );

    modport slave (
        output IRQ, INSTR_DONE, MRET, CSR_MIE, CSR_MTVEC, CSR_MEPC,
        input  INT_TAKEN, PC_REDIRECT, TRAP_PC, MIE_RESTORE, CAUSE, IN_ISR, PENDING
    );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt sequencer for the OTTER MCU.
// It synchronizes and edge-detects the IRQ lines and latches each rise as a
// pending bit. It takes the lowest pending index when MIE is set at an
// instruction boundary, and redirects the PC to MTVEC on a take and to MEPC on
// MRET.
// Ports:
//   CLK   : system clock; all state changes on the rising edge.
//   RST_N : synchronous active-low reset.
//   bus   : intr_ctrl_if.master, carrying the IRQ, boundary, MRET and CSR
//           inputs and the registered take/redirect/status outputs.
//
// state | meaning
// IDLE  | waiting for a take condition or a stray mret
// TAKE  | INT_TAKEN and PC_REDIRECT to MTVEC asserted this cycle
// ISR   | handler running; new edges only latch as pending
// RET   | PC_REDIRECT to MEPC plus MIE_RESTORE asserted this cycle
module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    intr_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, TAKE, ISR, RET} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] sync1, sync2, hist;
    logic [NUM_SRC-1:0] pending;
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        trap_pc;
    logic               int_taken, pc_redirect, mie_restore, in_isr;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] win_oh;
    logic [CAUSE_W-1:0] winner;
    logic               take;
    logic [NUM_SRC-1:0] pending_nxt;

    assign rise = sync2 & ~hist;

    // Scan from high to low so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        win_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner    = CAUSE_W'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // MRET has priority over a take. A take is also held off for one cycle
    // after a redirect, so that PC_REDIRECT is never high two cycles running.
    assign take = (state == IDLE) && (|pending) && bus.CSR_MIE && bus.INSTR_DONE
                  && !bus.MRET && !pc_redirect;

    // A rise on the bit being cleared re-sets it, so the new event is kept.
    assign pending_nxt = (pending & ~(take ? win_oh : '0)) | rise;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            sync1       <= '0;
            sync2       <= '0;
            hist        <= '0;
            pending     <= '0;
            cause       <= '0;
            trap_pc     <= '0;
            int_taken   <= 1'b0;
            pc_redirect <= 1'b0;
            mie_restore <= 1'b0;
            in_isr      <= 1'b0;
        end else begin
            sync1       <= bus.IRQ;
            sync2       <= sync1;
            hist        <= sync2;
            pending     <= pending_nxt;
            int_taken   <= 1'b0;
            pc_redirect <= 1'b0;
            mie_restore <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MRET) begin
                        pc_redirect <= 1'b1;
                        trap_pc     <= bus.CSR_MEPC;
                    end else if (take) begin
                        state       <= TAKE;
                        cause       <= winner;
                        trap_pc     <= bus.CSR_MTVEC;
                        int_taken   <= 1'b1;
                        pc_redirect <= 1'b1;
                        in_isr      <= 1'b1;
                    end
                end
                TAKE: begin
                    state <= ISR;
                end
                ISR: begin
                    if (bus.MRET) begin
                        state       <= RET;
                        trap_pc     <= bus.CSR_MEPC;
                        pc_redirect <= 1'b1;
                        mie_restore <= 1'b1;
                    end
                end
                RET: begin
                    state  <= IDLE;
                    in_isr <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    in_isr <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INT_TAKEN   = int_taken;
    assign bus.PC_REDIRECT = pc_redirect;
    assign bus.TRAP_PC     = trap_pc;
    assign bus.MIE_RESTORE = mie_restore;
    assign bus.CAUSE       = cause;
    assign bus.IN_ISR      = in_isr;
    assign bus.PENDING     = pending;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    logic CLK;
    logic RST_N;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    intr_ctrl_if #(.NUM_SRC(4), .CAUSE_W(2)) bus ();

    intr_ctrl #(.NUM_SRC(4), .CAUSE_W(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        RST_N          = 1'b0;
        bus.IRQ        = 4'b1111;
        bus.INSTR_DONE = 1'b0;
        bus.MRET       = 1'b0;
        bus.CSR_MIE    = 1'b0;
        bus.CSR_MTVEC  = 32'h0000_0100;
        bus.CSR_MEPC   = 32'h0000_0048;
        #1;

        // Reset held two cycles with every IRQ high
        tick(2);
        chk("rst_int_taken", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("rst_pc_redirect", {31'b0, bus.PC_REDIRECT}, 32'd0);
        chk("rst_mie_restore", {31'b0, bus.MIE_RESTORE}, 32'd0);
        chk("rst_in_isr", {31'b0, bus.IN_ISR}, 32'd0);
        chk("rst_pending", {28'b0, bus.PENDING}, 32'd0);
        chk("rst_cause", {30'b0, bus.CAUSE}, 32'd0);
        chk("rst_trap_pc", bus.TRAP_PC, 32'd0);
        RST_N = 1'b1;
        tick(2);
        chk("sync_latency_2", {28'b0, bus.PENDING}, 32'h0);
        tick(1);
        chk("sync_latency_3", {28'b0, bus.PENDING}, 32'hF);

        // Clear everything and let the synchronizers settle with IRQ low
        RST_N   = 1'b0;
        bus.IRQ = 4'b0000;
        tick(1);
        RST_N = 1'b1;
        tick(3);
        chk("pend_cleared", {28'b0, bus.PENDING}, 32'h0);

        // Basic take of IRQ[2]
        bus.CSR_MIE = 1'b1;
        bus.IRQ     = 4'b0100;
        tick(3);
        chk("basic_pending", {28'b0, bus.PENDING}, 32'h4);
        bus.INSTR_DONE = 1'b1;
        tick(1);
        bus.INSTR_DONE = 1'b0;
        bus.CSR_MIE    = 1'b0;
        chk("basic_int_taken", {31'b0, bus.INT_TAKEN}, 32'd1);
        chk("basic_pc_redirect", {31'b0, bus.PC_REDIRECT}, 32'd1);
        chk("basic_trap_pc", bus.TRAP_PC, 32'h100);
        chk("basic_cause", {30'b0, bus.CAUSE}, 32'd2);
        chk("basic_pending_clr", {28'b0, bus.PENDING}, 32'h0);
        chk("basic_in_isr", {31'b0, bus.IN_ISR}, 32'd1);
        tick(1);
        chk("isr_int_taken_low", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("isr_pc_redirect_low", {31'b0, bus.PC_REDIRECT}, 32'd0);
        chk("isr_in_isr", {31'b0, bus.IN_ISR}, 32'd1);
        tick(4);
        chk("level_sets_once", {28'b0, bus.PENDING}, 32'h0);

        // Return from the handler
        bus.MRET = 1'b1;
        tick(1);
        bus.MRET    = 1'b0;
        bus.CSR_MIE = 1'b1;
        chk("ret_pc_redirect", {31'b0, bus.PC_REDIRECT}, 32'd1);
        chk("ret_trap_pc", bus.TRAP_PC, 32'h48);
        chk("ret_mie_restore", {31'b0, bus.MIE_RESTORE}, 32'd1);
        chk("ret_int_taken", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("ret_in_isr", {31'b0, bus.IN_ISR}, 32'd1);
        tick(1);
        chk("post_ret_in_isr", {31'b0, bus.IN_ISR}, 32'd0);
        chk("post_ret_redirect", {31'b0, bus.PC_REDIRECT}, 32'd0);
        chk("post_ret_mie_restore", {31'b0, bus.MIE_RESTORE}, 32'd0);

        // Priority and masking: IRQ[3] and IRQ[1] rise together with MIE off
        bus.CSR_MIE = 1'b0;
        bus.IRQ     = 4'b1010;
        tick(3);
        chk("mask_pending", {28'b0, bus.PENDING}, 32'hA);
        bus.INSTR_DONE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("mask_no_take", {31'b0, bus.INT_TAKEN}, 32'd0);
        end
        chk("mask_pending_held", {28'b0, bus.PENDING}, 32'hA);
        bus.CSR_MIE = 1'b1;
        tick(1);
        bus.INSTR_DONE = 1'b0;
        bus.CSR_MIE    = 1'b0;
        chk("prio_int_taken", {31'b0, bus.INT_TAKEN}, 32'd1);
        chk("prio_cause", {30'b0, bus.CAUSE}, 32'd1);
        chk("prio_pending", {28'b0, bus.PENDING}, 32'h8);
        tick(1);

        // Nested edge on IRQ[0] while in the handler
        bus.IRQ        = 4'b1011;
        bus.INSTR_DONE = 1'b1;
        tick(3);
        bus.INSTR_DONE = 1'b0;
        chk("nest_pending", {28'b0, bus.PENDING}, 32'h9);
        chk("nest_no_take", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("nest_in_isr", {31'b0, bus.IN_ISR}, 32'd1);
        bus.MRET = 1'b1;
        tick(1);
        bus.MRET    = 1'b0;
        bus.CSR_MIE = 1'b1;
        chk("nest_ret_redirect", {31'b0, bus.PC_REDIRECT}, 32'd1);
        chk("nest_ret_mie_restore", {31'b0, bus.MIE_RESTORE}, 32'd1);
        tick(1);
        chk("nest_idle", {31'b0, bus.IN_ISR}, 32'd0);
        bus.INSTR_DONE = 1'b1;
        tick(1);
        bus.INSTR_DONE = 1'b0;
        bus.CSR_MIE    = 1'b0;
        chk("nest_take", {31'b0, bus.INT_TAKEN}, 32'd1);
        chk("nest_cause", {30'b0, bus.CAUSE}, 32'd0);
        chk("nest_pending_after", {28'b0, bus.PENDING}, 32'h8);
        tick(1);
        bus.MRET = 1'b1;
        tick(1);
        bus.MRET    = 1'b0;
        bus.CSR_MIE = 1'b1;
        tick(1);

        // MRET and a take condition in the same IDLE cycle
        bus.IRQ        = 4'b0000;
        bus.CSR_MEPC   = 32'h0000_0200;
        bus.MRET       = 1'b1;
        bus.INSTR_DONE = 1'b1;
        tick(1);
        bus.MRET       = 1'b0;
        bus.INSTR_DONE = 1'b0;
        bus.IRQ        = 4'b0100;
        chk("coll_redirect", {31'b0, bus.PC_REDIRECT}, 32'd1);
        chk("coll_trap_pc", bus.TRAP_PC, 32'h200);
        chk("coll_no_take", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("coll_no_mie_restore", {31'b0, bus.MIE_RESTORE}, 32'd0);
        chk("coll_pending_kept", {28'b0, bus.PENDING}, 32'h8);
        tick(1);
        chk("coll_next_no_take", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("coll_next_no_redirect", {31'b0, bus.PC_REDIRECT}, 32'd0);
        tick(1);
        bus.INSTR_DONE = 1'b1;
        tick(1);
        bus.INSTR_DONE = 1'b0;
        chk("retake_int_taken", {31'b0, bus.INT_TAKEN}, 32'd1);
        chk("retake_cause", {30'b0, bus.CAUSE}, 32'd3);
        chk("retake_trap_pc", bus.TRAP_PC, 32'h100);
        chk("retake_pending", {28'b0, bus.PENDING}, 32'h4);

        // Reset asserted while in TAKE
        RST_N = 1'b0;
        tick(1);
        chk("rst_take_int_taken", {31'b0, bus.INT_TAKEN}, 32'd0);
        chk("rst_take_pending", {28'b0, bus.PENDING}, 32'h0);
        chk("rst_take_in_isr", {31'b0, bus.IN_ISR}, 32'd0);
        chk("rst_take_redirect", {31'b0, bus.PC_REDIRECT}, 32'd0);
        chk("rst_take_cause", {30'b0, bus.CAUSE}, 32'd0);

        // A rise on the same bit being cleared by a take stays pending
        bus.IRQ = 4'b0000;
        RST_N   = 1'b1;
        tick(3);
        bus.IRQ = 4'b0001;
        tick(3);
        chk("same_bit_pending", {28'b0, bus.PENDING}, 32'h1);
        bus.IRQ = 4'b0000;
        tick(3);
        bus.IRQ = 4'b0001;
        tick(2);
        bus.INSTR_DONE = 1'b1;
        tick(1);
        bus.INSTR_DONE = 1'b0;
        chk("same_bit_take", {31'b0, bus.INT_TAKEN}, 32'd1);
        chk("same_bit_cause", {30'b0, bus.CAUSE}, 32'd0);
        chk("same_bit_kept", {28'b0, bus.PENDING}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt sequencer for the OTTER MCU, on the requesting side of the CSR file.
- Synchronizes and edge-detects external interrupt lines and latches them as pending.
- Arbitrates by fixed priority and gates the winner with CSR_MIE. Raises INT_TAKEN at an instruction boundary and supplies the trap/return PC redirect.
- On MRET, redirects to CSR_MEPC and requests MIE re-enable, because the CSR file clears MIE on every taken interrupt.

Parameters:
- NUM_SRC, 4, number of external interrupt lines (1..16).
- CAUSE_W, $clog2(NUM_SRC) (min 1), width of CAUSE.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST_N  in  1  reset, synchronous, active-low.
- IRQ  in  NUM_SRC  raw asynchronous interrupt lines, active-high, edge-triggered.
- INSTR_DONE  in  1  CPU FSM at instruction boundary (fetch state), one-cycle qualifier.
- MRET  in  1  mret committing this cycle, one-cycle pulse.
- CSR_MIE  in  1  global interrupt enable from CSR file.
- CSR_MTVEC  in  32  trap vector from CSR file.
- CSR_MEPC  in  32  return address from CSR file.
- INT_TAKEN  out  1  one-cycle pulse to CSR file (saves PC into MEPC, clears MIE) and CPU FSM.
- PC_REDIRECT  out  1  one-cycle pulse: CPU loads TRAP_PC as next PC.
- TRAP_PC  out  32  redirect target, valid only while PC_REDIRECT=1.
- MIE_RESTORE  out  1  one-cycle pulse: CSR MIE write with WD[0]=1.
- CAUSE  out  CAUSE_W  index of the last taken source, held until the next take.
- IN_ISR  out  1  high from INT_TAKEN until the matching MRET redirect.
- PENDING  out  NUM_SRC  latched pending bits.

Behaviour:
- Reset (RST_N=0 at posedge):
  - Synchronizers, edge history, PENDING, CAUSE, TRAP_PC, INT_TAKEN, PC_REDIRECT, MIE_RESTORE and IN_ISR all go to 0.
  - State goes to IDLE.
  - Reset mid-sequence abandons the sequence; no pulse completes.
- Input conditioning:
  - Each IRQ bit passes through a 2-flop synchronizer plus a history flop.
  - A rise is sync=1 and hist=0. A rise sets that PENDING bit.
  - Edge-to-PENDING latency is 3 cycles. A level held high sets PENDING only once.
- Arbitration: the winner is the lowest set index of PENDING.
- State machine, states IDLE, TAKE, ISR, RET:
  - IDLE: if |PENDING & CSR_MIE & INSTR_DONE, go to TAKE. At that edge, clear the winner's PENDING bit, set CAUSE to the winner, and register TRAP_PC=CSR_MTVEC.
  - TAKE (1 cycle): INT_TAKEN=1, PC_REDIRECT=1, IN_ISR=1. Next state is ISR.
  - ISR: IN_ISR=1. New edges still latch into PENDING; no take occurs, because CSR_MIE is 0 and the state is not IDLE.
  - ISR with MRET=1: go to RET with TRAP_PC=CSR_MEPC.
  - RET (1 cycle): PC_REDIRECT=1, MIE_RESTORE=1, IN_ISR=1. Next state is IDLE.
  - IDLE with MRET=1 (mret without an active trap): one-cycle PC_REDIRECT with TRAP_PC=CSR_MEPC, MIE_RESTORE=0, state stays IDLE.
  - IDLE with MRET and take both true in the same cycle: MRET wins. The take is re-evaluated at the next INSTR_DONE.
- Simultaneous events:
  - An edge on the same bit being cleared by a take leaves the bit set, so the new event is kept.
  - Multiple edges in one cycle all latch.
- All outputs are registered. INT_TAKEN, PC_REDIRECT and MIE_RESTORE are never high for two consecutive cycles.
- CSR_MIE=0: pending bits are held indefinitely and none is lost.

Test Plan:
- Reset with all outputs forced: hold RST_N=0 two cycles with IRQ=4'b1111 -> every output 0, state IDLE. After RST_N=1, PENDING=4'b1111 three cycles later.
- Basic take: CSR_MIE=1, CSR_MTVEC=32'h0000_0100, IRQ[2] rises, INSTR_DONE pulses once PENDING[2]=1 -> next cycle INT_TAKEN=1, PC_REDIRECT=1, TRAP_PC=0x100, CAUSE=2, PENDING[2]=0, IN_ISR=1.
- Priority and masking:
  - IRQ[3] and IRQ[1] rise together with CSR_MIE=0, then INSTR_DONE pulses repeatedly -> no INT_TAKEN, PENDING=4'b1010.
  - Set CSR_MIE=1 and pulse INSTR_DONE -> CAUSE=1, PENDING=4'b1000.
- Return: in ISR with CSR_MEPC=32'h0000_0048, pulse MRET -> next cycle PC_REDIRECT=1, TRAP_PC=0x48, MIE_RESTORE=1. The cycle after: IN_ISR=0, state IDLE.
- Nested edge: during ISR, IRQ[0] rises -> PENDING[0]=1, no INT_TAKEN. After the return and CSR_MIE back to 1, the next INSTR_DONE takes CAUSE=0.
- Collisions:
  - MRET and a take condition in the same IDLE cycle -> redirect to CSR_MEPC only, no INT_TAKEN.
  - Reset asserted during TAKE -> INT_TAKEN low the next cycle, PENDING=0.
